fas_fir_stream: RTL and testbench

Parametrised streaming FIR filter for the FAS datapath. It is the configurable successor to the fixed 32-tap FIR stage. It adds:
- generic tap count and fixed-point formats;
- run-time coefficient loading through a double-buffered coefficient bank;
- a synchronous history flush;
- optional output saturation.

It sits between the sample input (`data`/`data_valid`) and the FFT front end, producing one filtered sample per accepted input.

---
 rtl/fas_fir_pkg.sv | 51 +++++
 rtl/fas_fir_round_sat.sv | 35 +++
 rtl/fas_fir_stream.sv | 136 +++++++++++++
 tb/tb_fas_fir_stream.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fas_fir_pkg.sv
// Shared constants and fixed-point helpers for the FAS streaming FIR.
// Default formats: Q8.8 samples, Q4.16 coefficients, Q8.8 output.
package fas_fir_pkg;

    localparam int unsigned FIR_DEF_TAPS      = 32;
    localparam int          FIR_DEF_DIN_W     = 16;
    localparam int          FIR_DEF_DIN_FRAC  = 8;
    localparam int          FIR_DEF_COEF_W    = 20;
    localparam int          FIR_DEF_COEF_FRAC = 16;
    localparam int          FIR_DEF_DOUT_W    = 16;
    localparam int          FIR_DEF_DOUT_FRAC = 8;

    localparam int FIR_MAX_W = 128;
    typedef logic signed [FIR_MAX_W-1:0] fir_wide_t;

    function automatic int fir_acc_w(input int din_w, input int coef_w, input int unsigned taps);
        return din_w + coef_w + $clog2(taps);
    endfunction

    function automatic int fir_sh(input int din_frac, input int coef_frac, input int dout_frac);
        return din_frac + coef_frac - dout_frac;
    endfunction

    // Round half up, then arithmetic shift right by sh.
    function automatic fir_wide_t fir_round(input fir_wide_t v, input int sh);
        fir_wide_t half;
        half = '0;
        if (sh > 0) begin
            half = fir_wide_t'(1) <<< (sh - 1);
        end
        return (v + half) >>> sh;
    endfunction

    function automatic logic fir_out_of_range(input fir_wide_t v, input int w);
        fir_wide_t lim;
        lim = fir_wide_t'(1) <<< (w - 1);
        return (v >= lim) || (v < -lim);
    endfunction

    function automatic fir_wide_t fir_saturate(input fir_wide_t v, input int w);
        fir_wide_t lim;
        lim = fir_wide_t'(1) <<< (w - 1);
        if (v >= lim) begin
            return lim - fir_wide_t'(1);
        end else if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/fas_fir_round_sat.sv
// Combinational round/shift/reduce of the FIR accumulator to the output width.
// FIR_SAT_EN selects clamping with overflow indication; otherwise two's-complement wrap.
module fas_fir_round_sat
    import fas_fir_pkg::*;
#(
    parameter int ACC_W  = 41,
    parameter int DOUT_W = 16,
    parameter int SH     = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     ovf
);

    fir_wide_t wide;
    fir_wide_t rnd;
    logic      unused_hi;

    assign wide = fir_wide_t'(acc);
    assign rnd  = fir_round(wide, SH);

`ifdef FIR_SAT_EN
    fir_wide_t sat;

    assign sat       = fir_saturate(rnd, DOUT_W);
    assign dout      = sat[DOUT_W-1:0];
    assign ovf       = fir_out_of_range(rnd, DOUT_W);
    assign unused_hi = ^sat[FIR_MAX_W-1:DOUT_W];
`else
    assign dout      = rnd[DOUT_W-1:0];
    assign ovf       = 1'b0;
    assign unused_hi = ^rnd[FIR_MAX_W-1:DOUT_W];
`endif

endmodule

// File: rtl/fas_fir_stream.sv
// Streaming FIR with double-buffered coefficients, flush and 2-cycle latency.
// Output saturation and the sticky ovf flag are enabled by defining FIR_SAT_EN.
module fas_fir_stream
    import fas_fir_pkg::*;
#(
    parameter int unsigned TAPS      = FIR_DEF_TAPS,
    parameter int          DIN_W     = FIR_DEF_DIN_W,
    parameter int          DIN_FRAC  = FIR_DEF_DIN_FRAC,
    parameter int          COEF_W    = FIR_DEF_COEF_W,
    parameter int          COEF_FRAC = FIR_DEF_COEF_FRAC,
    parameter int          DOUT_W    = FIR_DEF_DOUT_W,
    parameter int          DOUT_FRAC = FIR_DEF_DOUT_FRAC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      din_valid,
    input  logic signed [DIN_W-1:0]   din,
    input  logic                      flush,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    input  logic                      coef_swap,
    output logic                      dout_valid,
    output logic signed [DOUT_W-1:0]  dout,
    output logic                      ovf
);

    localparam int ACC_W  = fir_acc_w(DIN_W, COEF_W, TAPS);
    localparam int SH     = fir_sh(DIN_FRAC, COEF_FRAC, DOUT_FRAC);
    localparam int PROD_W = DIN_W + COEF_W;

    logic signed [COEF_W-1:0] shadow [TAPS];
    logic signed [COEF_W-1:0] active [TAPS];
    logic signed [COEF_W-1:0] coef_s [TAPS];
    logic signed [DIN_W-1:0]  x      [TAPS];
    logic signed [PROD_W-1:0] prod   [TAPS];
    logic                     v0;
    logic                     v1;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DOUT_W-1:0] rs_dout;
    logic                     rs_ovf;

    // Non-blocking copy means a same-cycle write lands after the swap reads shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            if (coef_we && (32'(coef_addr) < TAPS)) begin
                shadow[coef_addr] <= coef_data;
            end
            if (coef_swap) begin
                for (int unsigned k = 0; k < TAPS; k++) begin
                    active[k] <= shadow[k];
                end
            end
        end
    end

    // coef_s freezes the bank seen at acceptance so a same-cycle swap affects only later samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                x[k]      <= '0;
                coef_s[k] <= '0;
            end
            v0 <= 1'b0;
        end else if (flush) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                x[k] <= '0;
            end
            v0 <= 1'b0;
        end else begin
            v0 <= din_valid;
            if (din_valid) begin
                x[0] <= din;
                for (int unsigned k = 1; k < TAPS; k++) begin
                    x[k] <= x[k-1];
                end
                for (int unsigned k = 0; k < TAPS; k++) begin
                    coef_s[k] <= active[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                prod[k] <= '0;
            end
            v1 <= 1'b0;
        end else begin
            v1 <= v0 && !flush;
            if (v0) begin
                for (int unsigned k = 0; k < TAPS; k++) begin
                    prod[k] <= PROD_W'(x[k]) * PROD_W'(coef_s[k]);
                end
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            acc = acc + ACC_W'(prod[k]);
        end
    end

    fas_fir_round_sat #(
        .ACC_W (ACC_W),
        .DOUT_W(DOUT_W),
        .SH    (SH)
    ) u_round_sat (
        .acc (acc),
        .dout(rs_dout),
        .ovf (rs_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            dout_valid <= v1 && !flush;
            if (v1 && !flush) begin
                dout <= rs_dout;
                ovf  <= ovf | rs_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fas_fir_stream.sv
// Directed self-checking bench for fas_fir_stream (default parameters).
// Honours FIR_SAT_EN for the overflow expectations.
module tb_fas_fir_stream;

`ifdef FIR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din_valid;
    logic [15:0] din;
    logic        flush;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [19:0] coef_data;
    logic        coef_swap;
    logic        dout_valid;
    logic [15:0] dout;
    logic        ovf;

    int checks   = 0;
    int failures = 0;
    string phase = "reset";

    // Expected-output delay line: acceptance -> 2 edges -> visible
    logic        pv0 = 1'b0, pv1 = 1'b0;
    logic [15:0] pd0 = '0, pd1 = '0, last_d = '0;

    typedef struct {
        int          setup;
        logic [15:0] din;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fas_fir_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_valid (din_valid),
        .din       (din),
        .flush     (flush),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef_swap (coef_swap),
        .dout_valid(dout_valid),
        .dout      (dout),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%s] actual=%h required=%h", name, phase, act, exp);
        end
    endtask

    function automatic logic [19:0] coef_of(input int s, input int k);
        case (s)
            0:       return (k == 0) ? 20'h10000 : 20'h00000;
            1:       return 20'(k << 12);
            2:       return (k == 0) ? 20'h08000 : 20'h00000;
            3:       return (k == 0) ? 20'h40000 : 20'h00000;
            default: return 20'h10000;
        endcase
    endfunction

    task automatic tick(input logic [15:0] exp);
        logic        ov;
        logic [15:0] od;
        ov  = pv1 && !flush;
        od  = pd1;
        pv1 = pv0 && !flush;
        pd1 = pd0;
        pv0 = din_valid && !flush;
        pd0 = exp;
        @(posedge clk);
        #1;
        if (ov) last_d = od;
        chk("dout_valid", 32'(dout_valid), 32'(ov));
        chk("dout", 32'(dout), 32'(last_d));
    endtask

    task automatic load_setup(input int s);
        for (int k = 0; k < 32; k++) begin
            coef_we   = 1'b1;
            coef_addr = 5'(k);
            coef_data = coef_of(s, k);
            tick(16'h0000);
        end
        coef_we   = 1'b0;
        coef_swap = 1'b1;
        tick(16'h0000);
        coef_swap = 1'b0;
        flush     = 1'b1;
        tick(16'h0000);
        flush     = 1'b0;
    endtask

    initial begin
        int cur;
        rst_n = 1'b1; din_valid = 1'b0; din = '0; flush = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_swap = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("reset_dout_valid", 32'(dout_valid), 32'd0);
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        tick(16'h0000);
        tick(16'h0000);
        rst_n = 1'b1;

        vecs.push_back('{0, 16'h0100, 16'h0100});
        vecs.push_back('{0, 16'hFF00, 16'hFF00});
        vecs.push_back('{0, 16'h1234, 16'h1234});
        vecs.push_back('{1, 16'h0100, 16'h0000});
        for (int n = 1; n <= 40; n++)
            vecs.push_back('{1, 16'h0000, (n < 32) ? 16'(n * 16) : 16'h0000});
        vecs.push_back('{2, 16'h0001, 16'h0001});
        vecs.push_back('{2, 16'hFFFF, 16'h0000});
        vecs.push_back('{2, 16'h0003, 16'h0002});
        vecs.push_back('{2, 16'hFFFD, 16'hFFFF});
        vecs.push_back('{3, 16'h7FFF, SAT ? 16'h7FFF : 16'hFFFC});
        vecs.push_back('{3, 16'h0001, 16'h0004});
        vecs.push_back('{3, 16'h8000, SAT ? 16'h8000 : 16'h0000});
        vecs.push_back('{3, 16'h0002, 16'h0008});

        phase = "table";
        cur = -1;
        foreach (vecs[i]) begin
            if (vecs[i].setup != cur) begin
                din_valid = 1'b0;
                chk("ovf_before_overflow", 32'(ovf), 32'd0);
                load_setup(vecs[i].setup);
                cur = vecs[i].setup;
            end
            din_valid = 1'b1;
            din       = vecs[i].din;
            tick(vecs[i].exp);
        end
        din_valid = 1'b0;
        tick(16'h0000);
        tick(16'h0000);
        chk("ovf_sticky", 32'(ovf), 32'(SAT));

        phase = "swap_collision";
        load_setup(0);
        coef_we = 1'b1; coef_addr = 5'd0; coef_data = 20'h20000;
        tick(16'h0000);
        coef_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din_valid = 1'b1;
            din       = 16'h0100;
            if (i == 3) begin
                coef_swap = 1'b1; coef_we = 1'b1; coef_addr = 5'd0; coef_data = 20'h30000;
            end
            if (i == 6) coef_swap = 1'b1;
            tick((i <= 3) ? 16'h0100 : (i <= 6) ? 16'h0200 : 16'h0300);
            coef_swap = 1'b0;
            coef_we   = 1'b0;
        end
        din_valid = 1'b0;
        tick(16'h0000);
        tick(16'h0000);

        phase = "flush";
        load_setup(4);
        for (int i = 0; i < 34; i++) begin
            din_valid = 1'b1;
            din       = 16'h0100;
            tick((i < 32) ? 16'((i + 1) * 256) : 16'h2000);
        end
        flush = 1'b1;
        tick(16'h5555);
        flush     = 1'b0;
        din_valid = 1'b0;
        tick(16'h0000);
        tick(16'h0000);
        din_valid = 1'b1;
        tick(16'h0100);
        din_valid = 1'b0;
        tick(16'h0000);
        tick(16'h0000);
        tick(16'h0000);
        chk("ovf_after_flush", 32'(ovf), 32'(SAT));

        phase = "reset_midstream";
        din_valid = 1'b1;
        tick(16'h0200);
        tick(16'h0300);
        tick(16'h0400);
        #2 rst_n = 1'b0;
        #1;
        pv0 = 1'b0; pv1 = 1'b0; last_d = '0;
        din_valid = 1'b0;
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        tick(16'h0000);
        tick(16'h0000);
        rst_n = 1'b1;
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick(16'h0000);
        din_valid = 1'b0;
        load_setup(0);
        din_valid = 1'b1;
        tick(16'h0100);
        din_valid = 1'b0;
        tick(16'h0000);
        tick(16'h0000);
        tick(16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
